// File: rtl/lfsr_rng_arbiter_pkg.sv
// Shared definitions for the LFSR random-word arbiter: FSM state encoding,
// warm-up counter width and the Galois step function (also usable by reference models).
package lfsr_rng_arbiter_pkg;

  typedef enum logic [0:0] {
    WARM  = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned WARM_W = 8;

  // One Galois step on the low w bits of r; the inserted bit is the complement of the old msb.
  function automatic logic [31:0] lfsr_next(input logic [31:0] r, input logic [31:0] poly,
                                            input int unsigned w);
    logic        msb;
    logic [4:0]  idx;
    logic [31:0] mask;
    logic [31:0] t;
    idx  = 5'(w - 32'd1);
    msb  = r[idx];
    mask = (w >= 32'd32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    t    = (r ^ (msb ? poly : 32'd0)) << 1;
    t    = t | {31'd0, ~msb};
    return t & mask;
  endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_if.sv
// Requester/seed bus of the LFSR random-word arbiter; master is the consumer side,
// slave is the arbiter.
interface lfsr_rng_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
);
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  ack;
  logic [WIDTH-1:0] rnd_out;
  logic             seed_wr;
  logic [WIDTH-1:0] seed_data;
  logic             busy;
  logic [15:0]      served_cnt;

  modport master (
    output req, seed_wr, seed_data,
    input  ack, rnd_out, busy, served_cnt
  );

  modport slave (
    input  req, seed_wr, seed_data,
    output ack, rnd_out, busy, served_cnt
  );
endinterface

// File: rtl/lfsr_rng_arbiter_lfsr_step_reg.sv
// WIDTH-bit Galois LFSR register that advances only when stepped; load wins over step,
// async reset clears it to zero.
module lfsr_step_reg
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = 16'h847d
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] step_s;

  assign step_s = WIDTH'(lfsr_next(32'(lfsr_q), 32'(POLY), WIDTH));

  // Next-state select: load, step or hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_value_i;
    end else if (step_i) begin
      lfsr_d = step_s;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter handing one fresh LFSR word per grant to NREQ requesters,
// with seed loading, post-seed warm-up and a delivered-word counter.
module lfsr_rng_arbiter
  import lfsr_rng_arbiter_pkg::*;
#(
  parameter int               NREQ   = 4,
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] POLY   = 16'h847d,
  parameter int               WARMUP = 4
) (
  input  logic                clk,
  input  logic                rst,
  lfsr_rng_arbiter_if.slave   bus
);

  localparam int               PTR_W    = $clog2(NREQ);
  localparam logic [0:0]       ST_WARM  = WARM;
  localparam logic [0:0]       ST_READY = READY;
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WARMUP);
  // With no warm-up, reset and seeding land directly in READY.
  localparam logic [0:0]       ST_START  = (WARMUP == 0) ? ST_READY : ST_WARM;
  localparam logic             BUSY_INIT = (WARMUP != 0);

  logic [0:0]        state_q, state_d;
  logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]  rnd_q, rnd_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0]       served_q, served_d;

  logic [WIDTH-1:0]  lfsr_s;
  logic              lfsr_step_s;
  logic [NREQ-1:0]   elig_s;
  logic [PTR_W-1:0]  cand_s;
  logic [PTR_W-1:0]  win_idx_s;
  logic              win_found_s;

  lfsr_step_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .load_i       (bus.seed_wr),
    .load_value_i (bus.seed_data),
    .step_i       (lfsr_step_s),
    .q_o          (lfsr_s)
  );

  // The requester acked this cycle is masked so its still-high req is not served twice.
  assign elig_s = bus.req & ~ack_q;

  // Round-robin search upward from rr_ptr+1, wrapping modulo NREQ.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand_s = PTR_W'((int'(rr_ptr_q) + i) % NREQ);
      if (!win_found_s && elig_s[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // FSM, grant, pointer and counter next-state; seeding overrides everything.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    busy_d      = busy_q;
    ack_d       = '0;
    rnd_d       = rnd_q;
    rr_ptr_d    = rr_ptr_q;
    served_d    = served_q;
    lfsr_step_s = 1'b0;
    if (bus.seed_wr) begin
      state_d    = ST_START;
      warm_cnt_d = WARM_INIT;
      busy_d     = BUSY_INIT;
    end else if (state_q == ST_WARM) begin
      lfsr_step_s = 1'b1;
      warm_cnt_d  = warm_cnt_q - 8'd1;
      if (warm_cnt_q == 8'd1) begin
        state_d = ST_READY;
        busy_d  = 1'b0;
      end else begin
        state_d = ST_WARM;
      end
    end else if (win_found_s) begin
      lfsr_step_s = 1'b1;
      ack_d       = NREQ'(1) << win_idx_s;
      rnd_d       = lfsr_s;
      rr_ptr_d    = win_idx_s;
      served_d    = served_q + 16'd1;
    end else begin
      ack_d = '0;
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_START;
      warm_cnt_q <= WARM_INIT;
      busy_q     <= BUSY_INIT;
      ack_q      <= '0;
      rnd_q      <= '0;
      rr_ptr_q   <= PTR_W'(NREQ - 1);
      served_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      rnd_q      <= rnd_d;
      rr_ptr_q   <= rr_ptr_d;
      served_q   <= served_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rnd_out    = rnd_q;
  assign bus.busy       = busy_q;
  assign bus.served_cnt = served_q;

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Shares one Galois LFSR random-word source among NREQ requesters; one fresh word per grant, round-robin fairness.
- Handles seed loading and post-seed warm-up, and counts delivered words.
- Sits between the pseudo-random source and its consumers (test-pattern, dither and backoff logic), replacing per-consumer free-running LFSRs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 16, LFSR and output word width.
- POLY, 16'h847d, Galois feedback mask, WIDTH bits.
- WARMUP, 4, LFSR steps after reset or seed load before serving (0..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NREQ  per-requester request level; held until own ack.
- ack  out  NREQ  one-hot, one-cycle pulse; word on rnd_out valid that cycle.
- rnd_out  out  WIDTH  random word, valid only while any ack bit is high; holds its last value otherwise.
- seed_wr  in  1  one-cycle pulse: load seed_data into the LFSR.
- seed_data  in  WIDTH  seed value.
- busy  out  1  high during warm-up; no grants issued.
- served_cnt  out  16  words delivered since reset, wraps at 16'hffff->0.

Behaviour:
- LFSR step: next = ((r ^ ({WIDTH{r[WIDTH-1]}} & POLY)) << 1) | ~r[WIDTH-1], truncated to WIDTH. The state advances only when stepped, never free-running.
- Reset values:
  - lfsr=0, ack=0, rnd_out=0, served_cnt=0.
  - rr_ptr=NREQ-1, so requester 0 has first priority.
  - state=WARM with warm_cnt=WARMUP. If WARMUP=0, state=READY and busy=0.
- WARM state:
  - busy=1; the LFSR steps once per cycle and warm_cnt decrements.
  - On the cycle warm_cnt reaches 0, the registered state becomes READY, and busy=0 from the next cycle.
  - Requests are ignored and not queued. They remain pending because requesters hold req.
- READY state:
  - Each cycle, eligible = req & ~ack. This masks the requester acked this cycle, so a req still high during its ack is not double-served.
  - If eligible is nonzero, the winner is the first set bit searching upward from rr_ptr+1, modulo NREQ.
  - Registered outputs next cycle: ack[winner]=1, rnd_out=current lfsr (value before the step). Also lfsr steps, rr_ptr=winner, served_cnt+1.
  - Latency: req sampled high at edge N yields ack at edge N+1. At most one grant per cycle.
  - Requesters must drop req in the cycle they see ack, or raise it again for another word.
- seed_wr:
  - Highest priority in any state. lfsr<=seed_data, state<=WARM, warm_cnt<=WARMUP, busy<=1 (if WARMUP=0: straight to READY, busy stays 0).
  - Any grant that would have been issued that cycle is suppressed (ack=0). rr_ptr and served_cnt are unchanged.
  - seed_wr during WARM restarts warm-up from the new seed.
  - The seed value is not validated. The user must avoid the single lock-up value of the chosen POLY.
- Simultaneous requests: only the round-robin winner is served; the others wait. The worst-case wait is NREQ-1 grants.
- Reset mid-transfer: everything returns to reset values immediately. An ack pulse in progress is cut.
- served_cnt counts ack pulses only; it does not count warm-up steps or seeds.

Decomposition:
- Shared package holds the step function (lfsr_next(r, poly)) and the FSM state enum {WARM, READY}. The same function also serves bench reference models.
- Natural sub-module: lfsr_step_reg, a WIDTH register with step enable, load/load_value and async reset to 0.
- The arbiter, FSM and counter stay in the top.

Test Plan:
- Reset, WARMUP=4, POLY=16'h847d; req=4'b0001 held from cycle 0 -> busy for 4 cycles. First ack[0] carries 16'h000f, second 16'h001f, third 16'h003f; served_cnt=3.
- Stepping continues through msb=1: starting from seed_data=16'h7fff, WARMUP=0, single requester -> words 16'h7fff then 16'hffff then 16'hf704.
- req=4'b1111 held continuously after warm-up -> acks rotate 0,1,2,3,0,... one per cycle. Each rnd_out equals lfsr_next of the previous word; no requester served twice in any 4 consecutive grants.
- req[2] drops on its ack, re-raises 3 cycles later while req[1] is held -> no double ack for req[2]; grant order respects rr_ptr.
- seed_wr with seed_data=16'h1234 in the same cycle a grant is due -> no ack that cycle and busy=1 for WARMUP cycles. The first word after is 4 steps past 16'h1234, and served_cnt is unchanged by the seed.
- Async rst asserted mid-grant-stream -> ack=0, rnd_out=0 and served_cnt=0 immediately. After release, the sequence repeats from 16'h000f and requester 0 wins first.
